// File: rtl/decode_regfile_if.sv
// Fetch-to-decode, write-back and decode-to-execute signals of the decode stage.
// Handshake: in_valid qualifies icode/rA/rB/valP; stall holds the output stage; out_valid qualifies registered results.
interface decode_regfile_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             stall;
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [WIDTH-1:0] valP;
    logic             cnd;
    logic [3:0]       wb_dstE;
    logic [WIDTH-1:0] wb_valE;
    logic [3:0]       wb_dstM;
    logic [WIDTH-1:0] wb_valM;
    logic             out_valid;
    logic             out_invalid;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;

    modport master (
        output in_valid, stall, icode, rA, rB, valP, cnd,
        output wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  out_valid, out_invalid, srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  in_valid, stall, icode, rA, rB, valP, cnd,
        input  wb_dstE, wb_valE, wb_dstM, wb_valM,
        output out_valid, out_invalid, srcA, srcB, dstE, dstM, valA, valB
    );
endinterface

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register-ID selection, register file with write-through
// bypass, and a stallable output register feeding execute.
module decode_regfile #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 15,
    parameter int RSP_ID = 4
) (
    input logic             clk,
    input logic             reset,
    decode_regfile_if.slave bus
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'(RSP_ID);
    localparam logic [4:0] NREGS_W = 5'(NREGS);

    logic [WIDTH-1:0] regs [0:NREGS-1];

    logic [3:0]       src_a;
    logic [3:0]       src_b;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
    logic [WIDTH-1:0] val_a_rd;
    logic [WIDTH-1:0] val_b_rd;
    logic [WIDTH-1:0] val_a;
    logic             bad_icode;

    function automatic logic in_range(input logic [3:0] id);
        return ({1'b0, id} < NREGS_W);
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            4'h2:                   src_a = bus.rA;
            4'h4, 4'h6, 4'hA:       src_a = bus.rA;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
        case (bus.icode)
            4'h4, 4'h5, 4'h6:       src_b = bus.rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
        case (bus.icode)
            4'h3, 4'h6:             dst_e = bus.rB;
            4'h2:                   dst_e = bus.cnd ? bus.rB : RNONE;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
        case (bus.icode)
            4'h5, 4'hB:             dst_m = bus.rA;
            default:                dst_m = RNONE;
        endcase
    end

    // Reads see the post-write value of a same-cycle write-back, M port first.
    always_comb begin
        val_a_rd = '0;
        val_b_rd = '0;
        if (src_a != RNONE && in_range(src_a)) begin
            if (bus.wb_dstM == src_a)      val_a_rd = bus.wb_valM;
            else if (bus.wb_dstE == src_a) val_a_rd = bus.wb_valE;
            else                           val_a_rd = regs[src_a];
        end
        if (src_b != RNONE && in_range(src_b)) begin
            if (bus.wb_dstM == src_b)      val_b_rd = bus.wb_valM;
            else if (bus.wb_dstE == src_b) val_b_rd = bus.wb_valE;
            else                           val_b_rd = regs[src_b];
        end
    end

    always_comb begin
        val_a = val_a_rd;
        if (bus.icode == 4'h7 || bus.icode == 4'h8) val_a = bus.valP;
    end

    assign bad_icode = (bus.icode > 4'hB);

    // The M write comes second so it overrides E when both target one register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (bus.wb_dstE != RNONE && in_range(bus.wb_dstE)) regs[bus.wb_dstE] <= bus.wb_valE;
            if (bus.wb_dstM != RNONE && in_range(bus.wb_dstM)) regs[bus.wb_dstM] <= bus.wb_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_invalid <= 1'b0;
            bus.srcA        <= RNONE;
            bus.srcB        <= RNONE;
            bus.dstE        <= RNONE;
            bus.dstM        <= RNONE;
            bus.valA        <= '0;
            bus.valB        <= '0;
        end else if (!bus.stall) begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid && !bad_icode) begin
                bus.out_invalid <= 1'b0;
                bus.srcA        <= src_a;
                bus.srcB        <= src_b;
                bus.dstE        <= dst_e;
                bus.dstM        <= dst_m;
                bus.valA        <= val_a;
                bus.valB        <= val_b_rd;
            end else begin
                // Bubble and illegal instruction both present empty IDs and zero operands.
                bus.out_invalid <= bus.in_valid;
                bus.srcA        <= RNONE;
                bus.srcB        <= RNONE;
                bus.dstE        <= RNONE;
                bus.dstM        <= RNONE;
                bus.valA        <= '0;
                bus.valB        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: expected outputs queued at issue, popped by a monitor.
module tb_decode_regfile;
  localparam int W  = 64;
  localparam int EW = 2 + 16 + 2 * W;
  localparam logic [EW-1:0] IDLE = {2'b00, 16'hFFFF, {(2 * W){1'b0}}};

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;

  decode_regfile_if #(.WIDTH(W)) bus ();

  decode_regfile #(.WIDTH(W), .NREGS(15), .RSP_ID(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] mk(input logic inv, input logic [3:0] sa, input logic [3:0] sb,
                                       input logic [3:0] de, input logic [3:0] dm,
                                       input logic [W-1:0] va, input logic [W-1:0] vb);
    return {1'b1, inv, sa, sb, de, dm, va, vb};
  endfunction

  function automatic logic [EW-1:0] actual();
    return {bus.out_valid, bus.out_invalid, bus.srcA, bus.srcB, bus.dstE, bus.dstM, bus.valA, bus.valB};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wb(input logic [3:0] de, input logic [W-1:0] ve, input logic [3:0] dm, input logic [W-1:0] vm);
    bus.wb_dstE = de;
    bus.wb_valE = ve;
    bus.wb_dstM = dm;
    bus.wb_valM = vm;
  endtask

  task automatic issue(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [W-1:0] vp, input logic c, input logic st);
    bus.in_valid = v;
    bus.icode    = ic;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.valP     = vp;
    bus.cnd      = c;
    bus.stall    = st;
    @(posedge clk);
    #1;
    wb(4'hF, '0, 4'hF, '0);
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
  endtask

  task automatic bubble();
    issue(1'b0, 4'h0, 4'hF, 4'hF, '0, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h expected no output", actual());
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (actual() !== e) begin
          bad++;
          $display("FAIL decode_out: got %h expected %h", actual(), e);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wb(4'hF, '0, 4'hF, '0);
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    bus.icode = 4'h0;
    bus.rA = 4'hF;
    bus.rB = 4'hF;
    bus.valP = '0;
    bus.cnd = 1'b0;
    bubble();
    bubble();
    reset = 1'b0;
    chk("reset_state", actual(), IDLE);
    bubble();
    chk("idle_bubble", actual(), IDLE);

    exp_q.push_back(mk(0, 4'h1, 4'h2, 4'h2, 4'hF, 0, 0));
    issue(1, 4'h6, 4'h1, 4'h2, 0, 0, 0);

    wb(4'h3, 64'h1234, 4'hF, 0);
    bubble();
    chk("bubble_after_op", actual(), IDLE);
    exp_q.push_back(mk(0, 4'h3, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h1234));
    issue(1, 4'h6, 4'h3, 4'h3, 0, 0, 0);

    wb(4'hF, 0, 4'h5, 64'hAA);
    exp_q.push_back(mk(0, 4'h5, 4'hF, 4'hF, 4'hF, 64'hAA, 0));
    issue(1, 4'h2, 4'h5, 4'h1, 0, 0, 0);
    exp_q.push_back(mk(0, 4'h3, 4'hF, 4'h6, 4'hF, 64'h1234, 0));
    issue(1, 4'h2, 4'h3, 4'h6, 0, 1, 0);

    wb(4'h4, 64'h10, 4'h4, 64'h20);
    bubble();
    exp_q.push_back(mk(0, 4'h4, 4'h4, 4'h4, 4'h7, 64'h20, 64'h20));
    issue(1, 4'hB, 4'h7, 4'hF, 0, 0, 0);
    exp_q.push_back(mk(0, 4'hF, 4'h4, 4'hF, 4'h8, 0, 64'h20));
    issue(1, 4'h5, 4'h8, 4'h4, 0, 0, 0);
    exp_q.push_back(mk(0, 4'hF, 4'hF, 4'h9, 4'hF, 0, 0));
    issue(1, 4'h3, 4'hF, 4'h9, 0, 0, 0);
    exp_q.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h77, 0));
    issue(1, 4'h7, 4'hF, 4'hF, 64'h77, 0, 0);
    wb(4'hF, 64'hDEAD, 4'hF, 0);
    exp_q.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0));
    issue(1, 4'h6, 4'h0, 4'h0, 0, 0, 0);
    exp_q.push_back(mk(0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h20, 64'h20));
    issue(1, 4'h9, 4'hF, 4'hF, 0, 0, 0);

    held = mk(0, 4'hF, 4'h4, 4'h4, 4'hF, 64'h40, 64'h20);
    exp_q.push_back(held);
    issue(1, 4'h8, 4'hF, 4'hF, 64'h40, 0, 0);
    wb(4'h1, 64'h99, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(held);
      issue(1, 4'h6, 4'h1, 4'h2, 64'h55, 0, 1);
    end
    bubble();
    chk("bubble_after_stall", actual(), IDLE);
    exp_q.push_back(mk(0, 4'h1, 4'h4, 4'h4, 4'hF, 64'h99, 64'h20));
    issue(1, 4'hA, 4'h1, 4'hF, 0, 0, 0);

    exp_q.push_back(mk(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0));
    issue(1, 4'hD, 4'h1, 4'h2, 0, 0, 0);
    exp_q.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0));
    issue(1, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    exp_q.push_back(mk(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0));
    issue(1, 4'hC, 4'h3, 4'h3, 0, 0, 0);
    exp_q.push_back(mk(1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0));
    issue(1, 4'h6, 4'h3, 4'h3, 0, 0, 1);

    reset = 1'b1;
    issue(1, 4'h6, 4'h3, 4'h4, 0, 0, 1);
    reset = 1'b0;
    chk("reset_in_stall", actual(), IDLE);
    exp_q.push_back(mk(0, 4'h3, 4'h4, 4'h4, 4'hF, 0, 0));
    issue(1, 4'h6, 4'h3, 4'h4, 0, 0, 0);
    bubble();
    chk("final_bubble", actual(), IDLE);
    bubble();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
